// File: rtl/bcd_counter_multi.sv
// bcd_counter_multi: multi-digit BCD up/down counter with clear, load and wrap pulse
// Ports: clk_50mhz clock; rst async active-high reset; cin count enable;
//        up_dn 1=up 0=down; clr sync clear; load/load_val sync BCD load;
//        q BCD count (digit 0 = q[3:0]); cout wrap/limit pulse; load_err rejected-load pulse.
// Define BCD_CNT_SAT_EN for saturating mode (hold at all-9 / all-0, cout flags the attempt).
module bcd_counter_multi #(
    parameter int DIGITS = 4
) (
    input  logic                  clk_50mhz,
    input  logic                  rst,
    input  logic                  cin,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  cout,
    output logic                  load_err
);
`ifdef BCD_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic [4*DIGITS-1:0] q_step;
    logic                carry;
    logic                bad_val;
    // carry doubles as borrow; it survives every digit only when the whole count wraps
    always_comb begin
        q_step  = q;
        carry   = 1'b1;
        bad_val = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry)
                q_step[4*i+:4] = up_dn ? (q[4*i+:4] == 4'd9 ? 4'd0 : q[4*i+:4] + 4'd1)
                                       : (q[4*i+:4] == 4'd0 ? 4'd9 : q[4*i+:4] - 4'd1);
            carry   = carry & (up_dn ? q[4*i+:4] == 4'd9 : q[4*i+:4] == 4'd0);
            bad_val = bad_val | (load_val[4*i+:4] > 4'd9);
        end
    end
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            q        <= '0;
            cout     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            cout     <= 1'b0;
            load_err <= 1'b0;
            if (clr)
                q <= '0;
            else if (load) begin
                if (bad_val)
                    load_err <= 1'b1;
                else
                    q <= load_val;
            end else if (cin) begin
                q    <= (SAT && carry) ? q : q_step;
                cout <= carry;
            end
        end
    end
endmodule

// File: tb/tb_bcd_counter_multi.sv
// tb_bcd_counter_multi: directed self-checking bench for bcd_counter_multi
module tb_bcd_counter_multi;
`ifdef BCD_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic        clk_50mhz = 1'b0;
    logic        rst = 1'b1, cin = 1'b0, up_dn = 1'b1, clr = 1'b0, load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] q;
    logic        cout, load_err;
    logic [7:0]  q2;
    logic        cout2, load_err2;
    int          total = 0, bad = 0;
    logic        cout_seen;

    bcd_counter_multi #(.DIGITS(4)) dut (
        .clk_50mhz(clk_50mhz), .rst(rst), .cin(cin), .up_dn(up_dn), .clr(clr),
        .load(load), .load_val(load_val), .q(q), .cout(cout), .load_err(load_err)
    );
    bcd_counter_multi #(.DIGITS(2)) dut2 (
        .clk_50mhz(clk_50mhz), .rst(rst), .cin(cin), .up_dn(up_dn), .clr(clr),
        .load(load), .load_val(load_val[7:0]), .q(q2), .cout(cout2), .load_err(load_err2)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (5) tick();
        chk("rst_q", q, 16'h0000);
        chk("rst_cout", {15'd0, cout}, 16'd0);
        chk("rst_lerr", {15'd0, load_err}, 16'd0);
        rst = 1'b0;
        cout_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cin = 1'b1; up_dn = 1'b1;
            tick();
            cin = 1'b0;
            cout_seen |= cout;
            if (i == 9) chk("t1_q10", q, 16'h0010);
            repeat (4) begin tick(); cout_seen |= cout; end
        end
        chk("t1_q30", q, 16'h0030);
        chk("t1_nocout", {15'd0, cout_seen}, 16'd0);
        cin = 1'b0; tick();
        chk("hold_q", q, 16'h0030);
        load = 1'b1; load_val = 16'h9998; tick(); load = 1'b0;
        chk("t2_load", q, 16'h9998);
        cin = 1'b1; up_dn = 1'b1; tick();
        chk("t2_q9999", q, 16'h9999);
        chk("t2_cout0", {15'd0, cout}, 16'd0);
        tick();
        chk("t2_wrap_q", q, SAT ? 16'h9999 : 16'h0000);
        chk("t2_wrap_cout", {15'd0, cout}, 16'd1);
        cin = 1'b0; tick();
        chk("t2_cout_pulse", {15'd0, cout}, 16'd0);
        load = 1'b1; load_val = 16'h1000; tick(); load = 1'b0;
        cin = 1'b1; up_dn = 1'b0; tick(); cin = 1'b0;
        chk("t3_borrow", q, 16'h0999);
        chk("t3_cout0", {15'd0, cout}, 16'd0);
        load = 1'b1; load_val = 16'h0000; tick(); load = 1'b0;
        cin = 1'b1; up_dn = 1'b0; tick(); cin = 1'b0;
        chk("t3_under_q", q, SAT ? 16'h0000 : 16'h9999);
        chk("t3_under_cout", {15'd0, cout}, 16'd1);
        tick();
        chk("t3_cout_pulse", {15'd0, cout}, 16'd0);
        load = 1'b1; load_val = 16'h12A4; cin = 1'b1; up_dn = 1'b1; tick();
        load = 1'b0; cin = 1'b0;
        chk("t4_q_kept", q, SAT ? 16'h0000 : 16'h9999);
        chk("t4_lerr", {15'd0, load_err}, 16'd1);
        chk("t4_nocount_cout", {15'd0, cout}, 16'd0);
        tick();
        chk("t4_lerr_pulse", {15'd0, load_err}, 16'd0);
        chk("t4_q_still", q, SAT ? 16'h0000 : 16'h9999);
        load = 1'b1; load_val = 16'h0100; tick(); load = 1'b0;
        cin = 1'b1; up_dn = 1'b0; tick(); cin = 1'b0;
        chk("mid_borrow", q, 16'h0099);
        cin = 1'b1; up_dn = 1'b1; tick(); cin = 1'b0;
        chk("mid_carry", q, 16'h0100);
        clr = 1'b1; load = 1'b1; load_val = 16'h1234; cin = 1'b1; tick();
        clr = 1'b0; load = 1'b0; cin = 1'b0;
        chk("t5_clr_q", q, 16'h0000);
        chk("t5_clr_cout", {15'd0, cout}, 16'd0);
        load = 1'b1; load_val = 16'h0567; tick(); load = 1'b0;
        chk("t5_load", q, 16'h0567);
        #3 rst = 1'b1;
        #1 chk("t5_async_rst", q, 16'h0000);
        tick();
        chk("t5_rst_hold", q, 16'h0000);
        rst = 1'b0; cin = 1'b1; up_dn = 1'b1; tick(); cin = 1'b0;
        chk("t5_resume", q, 16'h0001);
        load = 1'b1; load_val = 16'h0099; tick(); load = 1'b0;
        chk("t6_load99", {8'd0, q2}, 16'h0099);
        cin = 1'b1; up_dn = 1'b1;
        tick();
        chk("t6_up1_q", {8'd0, q2}, SAT ? 16'h0099 : 16'h0000);
        chk("t6_up1_cout", {15'd0, cout2}, 16'd1);
        tick();
        chk("t6_up2_q", {8'd0, q2}, SAT ? 16'h0099 : 16'h0001);
        chk("t6_up2_cout", {15'd0, cout2}, SAT ? 16'd1 : 16'd0);
        tick();
        cin = 1'b0;
        chk("t6_up3_q", {8'd0, q2}, SAT ? 16'h0099 : 16'h0002);
        chk("t6_up3_cout", {15'd0, cout2}, SAT ? 16'd1 : 16'd0);
        load = 1'b1; load_val = 16'h0000; tick(); load = 1'b0;
        cin = 1'b1; up_dn = 1'b0; tick(); cin = 1'b0;
        chk("t6_dn_q", {8'd0, q2}, SAT ? 16'h0000 : 16'h0099);
        chk("t6_dn_cout", {15'd0, cout2}, 16'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
